// File: rtl/rr_priority_encoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared constants and helpers for the round-robin / fixed
//                priority encoder family.
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    // Priority mode encodings carried on the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits (N=1/2 still need 1 bit).
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/rr_priority_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_priority_encoder_if
//  Description : Request/mode inputs and valid/ready index output of the
//                priority encoder. slave = encoder view, master = requester
//                and downstream consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_priority_encoder_if
    import encoder_pkg::*;
#(
    parameter int N = 8
) ();
    localparam int W = clog2_min1(N);

    logic [N-1:0] req;
    logic         enable;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         g;

    modport slave (
        input  req,
        input  enable,
        input  mode,
        input  out_ready,
        output out_valid,
        output out_idx,
        output g
    );

    modport master (
        output req,
        output enable,
        output mode,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  g
    );

endinterface : rr_priority_encoder_if
`default_nettype wire

// File: rtl/rr_priority_encoder_prio_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : prio_pick
//  Description : Combinational find-first-set over an N-bit vector. HIGH=1
//                returns the highest set bit, HIGH=0 the lowest. found is 0
//                (and idx 0) when the vector is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
    import encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter bit HIGH = 1'b1,
    localparam int W   = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    if (HIGH) begin : g_high
        // Ascending scan: the last set bit seen is the highest one.
        always_comb begin
            idx   = '0;
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end
    end else begin : g_low
        // Descending scan: the last set bit seen is the lowest one.
        always_comb begin
            idx   = '0;
            found = 1'b0;
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    idx   = W'(i);
                    found = 1'b1;
                end
            end
        end
    end

endmodule : prio_pick
`default_nettype wire

// File: rtl/rr_priority_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_priority_encoder
//  Description : Registered N-to-log2(N) priority encoder with fixed
//                (highest index wins) or round-robin priority and a
//                valid/ready output stage. g is the registered group flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_encoder
    import encoder_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = clog2_min1(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rr_priority_encoder_if.slave    bus
);

    logic [W-1:0] r_ptr;
    logic [W-1:0] r_idx;
    logic         r_valid;
    logic         r_g;

    logic [N-1:0] w_mask;
    logic [W-1:0] w_msk_idx;
    logic         w_msk_found;
    logic [W-1:0] w_lo_idx;
    logic         w_lo_found;
    logic [W-1:0] w_hi_idx;
    logic         w_hi_found;
    logic         w_any;
    logic [W-1:0] w_winner;
    logic [W-1:0] w_ptr_next;
    logic         w_cap;

    // Thermometer mask selecting request lines at or above the pointer.
    for (genvar i = 0; i < N; i++) begin : g_mask
        assign w_mask[i] = (r_ptr <= W'(i));
    end

    // Round-robin search restricted to lines >= ptr.
    prio_pick #(.N(N), .HIGH(1'b0)) u_rr_masked (
        .vec   (bus.req & w_mask),
        .idx   (w_msk_idx),
        .found (w_msk_found)
    );

    // Round-robin wrap candidate: lowest request overall.
    prio_pick #(.N(N), .HIGH(1'b0)) u_rr_raw (
        .vec   (bus.req),
        .idx   (w_lo_idx),
        .found (w_lo_found)
    );

    // Fixed-priority winner: highest request.
    prio_pick #(.N(N), .HIGH(1'b1)) u_fixed (
        .vec   (bus.req),
        .idx   (w_hi_idx),
        .found (w_hi_found)
    );

    // Both full-vector searches agree on whether any line is requesting.
    assign w_any = w_lo_found | w_hi_found;

    assign w_winner = (bus.mode == MODE_RR)
                    ? (w_msk_found ? w_msk_idx : w_lo_idx)
                    : w_hi_idx;

    // Pointer advances past the winner, wrapping at N-1 (not at 2**W).
    assign w_ptr_next = (w_winner == W'(N - 1)) ? '0 : W'(w_winner + 1'b1);

    // Capture when the output slot is empty or being drained this edge.
    assign w_cap = bus.enable & w_any & (~r_valid | bus.out_ready);

    // Output register: capture a winner, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else if (w_cap) begin
            r_valid <= 1'b1;
            r_idx   <= w_winner;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Rotating pointer moves only on round-robin captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_cap && (bus.mode == MODE_RR)) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Group flag follows enable & any-request every cycle, ignoring handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g <= 1'b0;
        end else begin
            r_g <= bus.enable & w_any;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.g         = r_g;

endmodule : rr_priority_encoder
`default_nettype wire

// File: tb/tb_rr_priority_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rr_priority_encoder
//  Description : Self-checking bench for rr_priority_encoder with N=8 and N=5
//                instances, a scan-based reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_priority_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_priority_encoder_if #(.N(8)) b8 ();
    rr_priority_encoder_if #(.N(5)) b5 ();

    rr_priority_encoder #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    rr_priority_encoder #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per instance: [0] = N=8, [1] = N=5.
    int m_valid [2] = '{0, 0};
    int m_idx   [2] = '{0, 0};
    int m_g     [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Winner by rule: fixed scans down from N-1; round robin scans the ring
    // starting at ptr and takes the first request met.
    function automatic int winner(input int n, input logic [7:0] rq,
                                  input logic md, input int ptr);
        if (md == 1'b0) begin
            for (int i = n - 1; i >= 0; i--)
                if (rq[i]) return i;
        end else begin
            for (int k = 0; k < n; k++)
                if (rq[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_step(input int id, input int n, input logic [7:0] rq,
                              input logic en, input logic md, input logic rdy);
        int  w;
        bit  any;
        any = (rq != 8'h00);
        if (en && any && (m_valid[id] == 0 || rdy)) begin
            w           = winner(n, rq, md, m_ptr[id]);
            m_idx[id]   = w;
            m_valid[id] = 1;
            if (md) m_ptr[id] = (w + 1) % n;
        end else if (m_valid[id] != 0 && rdy) begin
            m_valid[id] = 0;
        end
        m_g[id] = (en && any) ? 1 : 0;
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_idx[i] = 0; m_g[i] = 0; m_ptr[i] = 0;
            end
        end else begin
            model_step(0, 8, b8.req, b8.enable, b8.mode, b8.out_ready);
            model_step(1, 5, {3'b000, b5.req}, b5.enable, b5.mode, b5.out_ready);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("n8_valid", int'(b8.out_valid), m_valid[0]);
            check("n8_idx",   int'(b8.out_idx),   m_idx[0]);
            check("n8_g",     int'(b8.g),         m_g[0]);
            check("n5_valid", int'(b5.out_valid), m_valid[1]);
            check("n5_idx",   int'(b5.out_idx),   m_idx[1]);
            check("n5_g",     int'(b5.g),         m_g[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        b8.req       = 8'hFF;
        b8.enable    = 1'b1;
        b8.mode      = 1'b0;
        b8.out_ready = 1'b1;
        b5.req       = 5'b00000;
        b5.enable    = 1'b0;
        b5.mode      = 1'b0;
        b5.out_ready = 1'b1;

        // Reset holds outputs low even with all requests asserted.
        step();
        step();
        check("rst_valid", int'(b8.out_valid), 0);
        check("rst_idx",   int'(b8.out_idx),   0);
        check("rst_g",     int'(b8.g),         0);

        // First edge after release captures the highest request.
        rst_n = 1'b1;
        step();
        check("rel_idx",   int'(b8.out_idx),   7);
        check("rel_valid", int'(b8.out_valid), 1);
        check("rel_g",     int'(b8.g),         1);

        // Fixed priority stepping.
        b8.req = 8'h01; step(); check("fix_01", int'(b8.out_idx), 0);
        b8.req = 8'h06; step(); check("fix_06", int'(b8.out_idx), 2);
        b8.req = 8'h90; step(); check("fix_90", int'(b8.out_idx), 7);

        // Round robin over a full request vector, including the 7 -> 0 wrap.
        b8.mode = 1'b1;
        b8.req  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            check("rr_seq", int'(b8.out_idx), k % 8);
        end

        // Backpressure: index 5 held while req changes underneath.
        b8.mode = 1'b0;
        b8.req  = 8'h20;
        step();
        check("bp_cap5", int'(b8.out_idx), 5);
        b8.out_ready = 1'b0;
        b8.req       = 8'h02;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_hold_idx",   int'(b8.out_idx),   5);
            check("bp_hold_valid", int'(b8.out_valid), 1);
        end
        b8.out_ready = 1'b1;
        step();
        check("bp_recap_idx",   int'(b8.out_idx),   1);
        check("bp_recap_valid", int'(b8.out_valid), 1);

        // Enable gating: pending index survives enable falling.
        b8.out_ready = 1'b0;
        b8.req       = 8'h10;
        step();
        b8.enable = 1'b0;
        step();
        check("en_g",     int'(b8.g),         0);
        check("en_valid", int'(b8.out_valid), 1);
        check("en_idx",   int'(b8.out_idx),   1);
        b8.out_ready = 1'b1;
        step();
        check("en_drain_valid", int'(b8.out_valid), 0);

        // All-zero requests: nothing captured, group flag low.
        b8.enable = 1'b1;
        b8.req    = 8'h00;
        step();
        check("zero_valid", int'(b8.out_valid), 0);
        check("zero_g",     int'(b8.g),         0);

        // N=5 round robin: drive ptr to 4, then wrap to line 0.
        b5.enable = 1'b1;
        b5.mode   = 1'b1;
        b5.req    = 5'b01000;
        step();
        check("n5_cap3", int'(b5.out_idx), 3);
        b5.req = 5'b00001;
        step();
        check("n5_wrap0", int'(b5.out_idx), 0);
        b5.req = 5'b00011;
        step();
        check("n5_ptr1", int'(b5.out_idx), 1);
        b5.out_ready = 1'b0;
        step();
        check("n5_pend", int'(b5.out_valid), 1);

        // Asynchronous reset pulse between clock edges.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_n5_valid", int'(b5.out_valid), 0);
        check("arst_n5_idx",   int'(b5.out_idx),   0);
        check("arst_n8_valid", int'(b8.out_valid), 0);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_idx", int'(b5.out_idx), 0);
        b5.out_ready = 1'b1;
        step();
        check("post_rst_rr", int'(b5.out_idx), 1);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_priority_encoder
`default_nettype wire
